// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants, controller state encoding and control-bundle
// types used by the pipeline controller and its hazard detector.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int CNT_W = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Flush bits are set in reset so every stage register loads a bubble.
    localparam ctrl_t CTRL_RESET     = ctrl_t'(8'b11111_111);
    localparam ctrl_t CTRL_RUN       = ctrl_t'(8'b11111_000);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(8'b00000_001);
    localparam ctrl_t CTRL_BRANCH    = ctrl_t'(8'b11111_110);
    localparam ctrl_t CTRL_LOAD_USE  = ctrl_t'(8'b00111_010);

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the five-stage datapath (master) and the pipeline
// controller (slave): stage instruction fields in, stage enables/flushes out.
interface pipeline_ctrl_if;

    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       rs1_used_ID;
    logic       rs2_used_ID;
    logic [6:0] opcode_ID_EX;
    logic [4:0] rd_ID_EX;
    logic       branch_taken_EX;
    logic [6:0] opcode_EX_MEM;
    logic       dmem_ready;

    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;
    logic       dmem_req;
    logic [riscv_pkg::CNT_W-1:0] stall_cnt;
    logic [riscv_pkg::CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
        output opcode_ID_EX, rd_ID_EX, branch_taken_EX,
        output opcode_EX_MEM, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  dmem_req, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
        input  opcode_ID_EX, rd_ID_EX, branch_taken_EX,
        input  opcode_EX_MEM, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output dmem_req, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction currently in IF/ID.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic [6:0] opcode_ex_i,
    input  logic [4:0] rd_ex_i,
    output logic       load_use_o
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign ex_is_load = (opcode_ex_i == OP_LOAD) && (rd_ex_i != 5'd0);
    assign rs1_hit    = rs1_used_i && (rs1_i == rd_ex_i);
    assign rs2_hit    = rs2_used_i && (rs2_i == rd_ex_i);
    assign load_use_o = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: memory-wait FSM, stall/flush priority decode and
// saturating stall/flush performance counters.
module pipeline_ctrl
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    ctrl_state_e      state_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic  mem_op;
    logic  mem_stall;
    logic  load_use;
    logic  stall_evt;
    logic  flush_evt;
    logic  dmem_req_c;
    ctrl_t ctrl;

    hazard_detect u_hazard_detect (
        .rs1_i       (bus.rs1_ID),
        .rs2_i       (bus.rs2_ID),
        .rs1_used_i  (bus.rs1_used_ID),
        .rs2_used_i  (bus.rs2_used_ID),
        .opcode_ex_i (bus.opcode_ID_EX),
        .rd_ex_i     (bus.rd_ID_EX),
        .load_use_o  (load_use)
    );

    assign mem_op    = is_mem_op(bus.opcode_EX_MEM);
    assign mem_stall = mem_op && !bus.dmem_ready;
    // Lower-priority events only count when nothing above them wins the cycle.
    assign flush_evt = !mem_stall && bus.branch_taken_EX;
    assign stall_evt = mem_stall || (load_use && !bus.branch_taken_EX);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        ctrl       = CTRL_RUN;
        dmem_req_c = mem_op;
        if (!rst) begin
            ctrl       = CTRL_RESET;
            dmem_req_c = 1'b0;
        end else if (mem_stall) begin
            ctrl = CTRL_MEM_STALL;
        end else if (bus.branch_taken_EX) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt) stall_cnt_d = sat_inc(stall_cnt_q);
        if (flush_evt) flush_cnt_d = sat_inc(flush_cnt_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN:      if (mem_stall)      state_q <= MEM_WAIT;
                MEM_WAIT: if (bus.dmem_ready) state_q <= RUN;
                default:                      state_q <= RUN;
            endcase
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.dmem_req     = dmem_req_c;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, memory wait, priority, reset
// and counter saturation, with hand-computed expectations.
module tb_pipeline_ctrl;
    import riscv_pkg::*;

    localparam logic [6:0] OP_ALU = 7'b0110011;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush, dmem_req}
    localparam logic [8:0] C_NORM     = 9'b11111_000_0;
    localparam logic [8:0] C_NORM_REQ = 9'b11111_000_1;
    localparam logic [8:0] C_RST      = 9'b11111_111_0;
    localparam logic [8:0] C_MEM      = 9'b00000_001_1;
    localparam logic [8:0] C_LU       = 9'b00111_010_0;
    localparam logic [8:0] C_BR       = 9'b11111_110_0;
    localparam logic [8:0] C_BR_REQ   = 9'b11111_110_1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [8:0] ctrl_obs;
    assign ctrl_obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                       bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush, bus.dmem_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [6:0] op_ex, input logic [4:0] rd_ex,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic br, input logic [6:0] op_mem, input logic ready);
        bus.opcode_ID_EX    = op_ex;
        bus.rd_ID_EX        = rd_ex;
        bus.rs1_ID          = rs1;
        bus.rs1_used_ID     = u1;
        bus.rs2_ID          = rs2;
        bus.rs2_used_ID     = u2;
        bus.branch_taken_EX = br;
        bus.opcode_EX_MEM   = op_mem;
        bus.dmem_ready      = ready;
    endtask

    task automatic idle();
        drive(OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, OP_ALU, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset asserted with a load in MEM: bubbles everywhere, no memory request.
        rst = 1'b0;
        drive(OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, OP_LOAD, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctrl", 32'(ctrl_obs), 32'(C_RST));
        check("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(RUN));

        @(negedge clk); rst = 1'b1; idle(); #1;
        check("idle_ctrl", 32'(ctrl_obs), 32'(C_NORM));

        // Load x5 in EX, consumer reads rs1=x5: one-cycle load-use stall.
        @(negedge clk); drive(OP_LOAD, 5'd5, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, OP_ALU, 1'b1); #1;
        check("lu_rs1_ctrl", 32'(ctrl_obs), 32'(C_LU));
        @(negedge clk); idle(); #1;
        check("lu_rs1_release", 32'(ctrl_obs), 32'(C_NORM));
        check("lu_rs1_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Load writing x0 never stalls.
        @(negedge clk); drive(OP_LOAD, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, OP_ALU, 1'b1); #1;
        check("lu_x0_ctrl", 32'(ctrl_obs), 32'(C_NORM));

        // rs2 dependency stalls; unused rs2 and non-load producers do not.
        @(negedge clk); drive(OP_LOAD, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, OP_ALU, 1'b1); #1;
        check("lu_rs2_ctrl", 32'(ctrl_obs), 32'(C_LU));
        @(negedge clk); drive(OP_LOAD, 5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, OP_ALU, 1'b1); #1;
        check("lu_rs2_unused", 32'(ctrl_obs), 32'(C_NORM));
        @(negedge clk); drive(OP_ALU, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, OP_ALU, 1'b1); #1;
        check("alu_no_stall", 32'(ctrl_obs), 32'(C_NORM));
        check("stall_cnt_after_lu", 32'(bus.stall_cnt), 32'd2);

        // Store in MEM with dmem_ready low for three cycles.
        @(negedge clk); drive(OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, OP_STORE, 1'b0); #1;
        check("st_wait1_ctrl", 32'(ctrl_obs), 32'(C_MEM));
        check("st_wait1_state", 32'(dut.state_q), 32'(RUN));
        @(negedge clk); #1;
        check("st_wait2_ctrl", 32'(ctrl_obs), 32'(C_MEM));
        check("st_wait2_state", 32'(dut.state_q), 32'(MEM_WAIT));
        @(negedge clk); #1;
        check("st_wait3_ctrl", 32'(ctrl_obs), 32'(C_MEM));
        check("st_wait3_state", 32'(dut.state_q), 32'(MEM_WAIT));
        @(negedge clk); bus.dmem_ready = 1'b1; #1;
        check("st_done_ctrl", 32'(ctrl_obs), 32'(C_NORM_REQ));
        check("st_done_stall_cnt", 32'(bus.stall_cnt), 32'd5);
        @(negedge clk); idle(); #1;
        check("st_back_to_run", 32'(dut.state_q), 32'(RUN));
        check("st_stall_cnt_hold", 32'(bus.stall_cnt), 32'd5);

        // Branch held across a memory stall takes effect on the release cycle.
        @(negedge clk); drive(OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, OP_LOAD, 1'b0); #1;
        check("br_in_stall_ctrl", 32'(ctrl_obs), 32'(C_MEM));
        @(negedge clk); bus.dmem_ready = 1'b1; #1;
        check("br_release_ctrl", 32'(ctrl_obs), 32'(C_BR_REQ));
        check("br_release_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        @(negedge clk); idle(); #1;
        check("br_release_stall_cnt", 32'(bus.stall_cnt), 32'd6);
        check("br_release_flush_cnt2", 32'(bus.flush_cnt), 32'd1);

        // Branch wins over a simultaneous load-use hazard.
        @(negedge clk); drive(OP_LOAD, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, OP_ALU, 1'b1); #1;
        check("br_lu_ctrl", 32'(ctrl_obs), 32'(C_BR));
        @(negedge clk); idle(); #1;
        check("br_lu_flush_cnt", 32'(bus.flush_cnt), 32'd2);
        check("br_lu_stall_cnt", 32'(bus.stall_cnt), 32'd6);

        // Reset in the middle of MEM_WAIT.
        @(negedge clk); drive(OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, OP_LOAD, 1'b0); #1;
        @(negedge clk); #1;
        check("mw_state", 32'(dut.state_q), 32'(MEM_WAIT));
        @(negedge clk); rst = 1'b0; #1;
        check("mw_rst_ctrl", 32'(ctrl_obs), 32'(C_RST));
        check("mw_rst_stall_before", 32'(bus.stall_cnt), 32'd8);
        @(negedge clk); #1;
        check("mw_rst_state", 32'(dut.state_q), 32'(RUN));
        check("mw_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("mw_rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        @(negedge clk); rst = 1'b1; idle(); #1;
        check("post_rst_ctrl", 32'(ctrl_obs), 32'(C_NORM));

        // Long memory stall drives stall_cnt into saturation.
        @(negedge clk); drive(OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, OP_LOAD, 1'b0); #1;
        check("sat_ctrl", 32'(ctrl_obs), 32'(C_MEM));
        repeat (65540) @(negedge clk);
        #1;
        check("sat_reached", 32'(bus.stall_cnt), 32'hFFFF);
        repeat (3) @(negedge clk);
        #1;
        check("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
        check("sat_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        @(negedge clk); idle(); #1;
        check("sat_release_ctrl", 32'(ctrl_obs), 32'(C_NORM));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: rs1_ID, rs2_ID  input  5 each  source registers of the instruction in IF/ID.
REQ-004 SHALL have: rs1_used_ID, rs2_used_ID  input  1 each  source actually read.
REQ-005 SHALL have: opcode_ID_EX, rd_ID_EX  input  7/5  instruction in EX.
REQ-006 SHALL have: branch_taken_EX  input  1  taken branch/jump resolved in EX.
REQ-007 SHALL have: opcode_EX_MEM  input  7  instruction in MEM.
REQ-008 SHALL have: dmem_ready  input  1  data memory completes the current access this cycle.
REQ-009 SHALL have: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  register load enables.
REQ-010 SHALL have: if_id_flush, id_ex_flush, mem_wb_flush  output  1 each  load bubble (all fields 0).
REQ-011 SHALL have: dmem_req  output  1  data memory access request.
REQ-012 SHALL have: stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT; reset state RUN.
REQ-014 SHALL define mem_op = opcode_EX_MEM is LOAD (0000011) or STORE (0100011); dmem_req = mem_op.
REQ-015 RUN->MEM_WAIT when mem_op and !dmem_ready; MEM_WAIT->RUN when dmem_ready; otherwise stay.
REQ-016 mem_stall = mem_op && !dmem_ready (either state); while mem_stall all five enables SHALL be 0 and mem_wb_flush 1; all other flushes 0.
REQ-017 Branch flush: when !mem_stall and branch_taken_EX, pc_en/all enables 1, if_id_flush=1, id_ex_flush=1.
REQ-018 Load-use: lu = opcode_ID_EX==LOAD, rd_ID_EX!=0, and (rs1_used_ID && rs1_ID==rd_ID_EX or rs2_used_ID && rs2_ID==rd_ID_EX).
REQ-019 When !mem_stall, !branch_taken_EX and lu: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
REQ-020 Priority SHALL be mem_stall > branch flush > load-use; branch held during mem_stall applies on the release cycle.
REQ-021 No hazard: all enables 1, all flushes 0.
REQ-022 Control outputs SHALL be combinational from inputs and state (zero latency); counters update next edge.
REQ-023 stall_cnt +1 each cycle with mem_stall or lu-stall; flush_cnt +1 each branch-flush cycle; both saturate at 0xFFFF.
REQ-024 A flush SHALL override enable on the same register (flush loads bubble even if enable deasserted).

Reset
REQ-025 When rst=0 at a clock edge: state=RUN, stall_cnt=0, flush_cnt=0, overriding any ongoing MEM_WAIT.
REQ-026 While rst=0, outputs SHALL be: all enables 1, if_id_flush/id_ex_flush/mem_wb_flush 1, dmem_req 0.

Structure
REQ-027 Opcode constants (LOAD, STORE, BRANCH, JAL, JALR) and FSM state encoding SHALL live in shared package riscv_pkg.
REQ-028 Hazard detection (REQ-018) SHALL be sub-module hazard_detect (combinational); counters and FSM in pipeline_ctrl.

Verification
REQ-029 Load x5 in EX, IF/ID add reads rs1=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
REQ-030 Load writes x0, consumer reads x0 -> no stall, all enables 1.
REQ-031 Store in MEM, dmem_ready low 3 cycles -> state MEM_WAIT, enables 0, mem_wb_flush 1 for 3 cycles; stall_cnt=3.
REQ-032 branch_taken_EX plus lu same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
REQ-033 rst=0 mid MEM_WAIT -> next cycle state RUN, counters 0; stall_cnt saturation forced at 0xFFFF holds at 0xFFFF.
